key_event: RTL
==============

Name: key_event

Overview:
- Upstream stage of the key counter / 7-segment path.
- Converts a raw, bouncy, active-low push-button into clean single-cycle events on the 12 MHz system clock: press, release, long-press and (optionally) auto-repeat.
- Replaces the free-running 100 Hz sampling debouncer.
- The counter stage consumes press_pulse synchronously instead of using a debounced signal as a clock.

Parameters:
- DB_CYCLES, 240000, stable-input cycles required to accept a level change (20 ms at 12 MHz).
- LONG_CYCLES, 12000000, cycles a press must be held (after the press is accepted) to raise long_pulse (1 s).
- REPEAT_CYCLES, 2400000, auto-repeat period after a long press (200 ms).

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  synchronous, active-low reset.
- key  input  1  raw button, asynchronous, active-low (0 = pressed).
- key_level  output  1  debounced state, 1 = pressed.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- long_pulse  output  1  one-cycle pulse when the long-press threshold is reached.
- repeat_pulse  output  1  one-cycle auto-repeat pulse; tied 0 without the macro.

Behaviour:
- Reset (rst=0 sampled on a rising clk edge):
  - All outputs are 0.
  - Synchronizer flops are 1 (released).
  - State is IDLE and all counters are 0.
  - Reset mid-press discards the press with no release_pulse. After reset a held key must pass full debounce again before press_pulse.
- Synchronizer: two flops; key_s = key delayed 2 cycles. key_n = ~key_s.
- Counters:
  - cnt is the debounce counter; hold_cnt is shared for long and repeat timing.
  - Each is wide enough for the maximum of its parameters.
  - Counters saturate and never wrap.
- State machine:
  - IDLE: key_level=0. key_n=1 -> PRESS_DB, cnt=0.
  - PRESS_DB: key_n=0 -> IDLE, no event (bounce rejected). key_n=1 and cnt==DB_CYCLES-1 -> HELD, press_pulse=1 for that one cycle, key_level=1, hold_cnt=0. Otherwise cnt++.
  - HELD: key_n=0 -> RELEASE_DB, cnt=0. hold_cnt==LONG_CYCLES-1 -> LONG_HELD, long_pulse=1, hold_cnt=0. Otherwise hold_cnt++.
  - LONG_HELD:
    - key_n=0 -> RELEASE_DB, cnt=0.
    - With the macro: hold_cnt==REPEAT_CYCLES-1 -> repeat_pulse=1, hold_cnt=0; otherwise hold_cnt++.
    - Without the macro: hold_cnt is idle.
  - RELEASE_DB: key_level stays 1 and hold_cnt is frozen.
    - key_n=1 -> return to the originating state (HELD or LONG_HELD, recorded in flag long_f) with hold_cnt unchanged and no event.
    - key_n=0 and cnt==DB_CYCLES-1 -> IDLE, release_pulse=1, key_level=0, long_f=0.
    - Otherwise cnt++.
- Timing: for a clean key fall registered at edge N, press_pulse is high in cycle N+2+DB_CYCLES. Release is symmetric.
- Simultaneous events: at most one pulse per cycle. Long and release cannot coincide because the release path passes through RELEASE_DB, which freezes hold_cnt.
- Press shorter than DB_CYCLES: no events at all.

Optional Feature:
- Macro: KEY_EVENT_REPEAT_EN.
- When defined: LONG_HELD generates repeat_pulse every REPEAT_CYCLES cycles. The first repeat occurs REPEAT_CYCLES cycles after long_pulse.
- When undefined: repeat_pulse is constant 0, the repeat compare logic is removed, and LONG_HELD only waits for release.

Decomposition:
- Shared package key_pkg:
  - state encodings: ST_IDLE=0, ST_PRESS_DB=1, ST_HELD=2, ST_LONG_HELD=3, ST_RELEASE_DB=4 (3-bit).
  - default cycle constants for 12 MHz.
- One sub-module key_sync: two-flop synchronizer with reset value 1, reused for the rst button path in the top level.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- Reset, key held 1 for 50 cycles -> all outputs 0, state IDLE.
- key 1->0 at cycle 10 and held -> press_pulse high only in cycle 16, key_level=1 from cycle 16. Then key 0->1 -> release_pulse one cycle 6 cycles after the edge, key_level=0.
- Bounce: key low 3 cycles, high 2, low 2, then high -> no pulses, key_level stays 0.
- Hold low 60 cycles -> press_pulse, then long_pulse 20 cycles after press_pulse. With KEY_EVENT_REPEAT_EN, repeat_pulse at +8, +16, +24… after long_pulse. Without the macro, repeat_pulse stays 0.
- In HELD, key high for 2 cycles then low -> no release_pulse, key_level stays 1, long_pulse delayed by exactly the frozen cycles.
- rst=0 for 1 cycle while in LONG_HELD -> outputs 0, no release_pulse. Key still low -> new press_pulse 2+DB_CYCLES(+1) cycles after rst returns to 1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button event path: FSM state encodings,
// default 12 MHz cycle constants and a counter-width helper.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_LONG_HELD  = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    localparam int unsigned DB_CYCLES_DEF     = 240000;    // 20 ms
    localparam int unsigned LONG_CYCLES_DEF   = 12000000;  // 1 s
    localparam int unsigned REPEAT_CYCLES_DEF = 2400000;   // 200 ms

    // Bits needed to hold 0 .. max_count-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return ($clog2(max_count) < 1) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous active-low button input.
// Resets to 1 so a synchronized button reads "released" out of reset.
module key_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops; reset parks both at released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_event.sv
// Push-button event generator: debounces an active-low raw key and emits
// single-cycle press, release, long-press and optional auto-repeat pulses.
// Optional feature: define KEY_EVENT_REPEAT_EN to enable repeat_pulse.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | key released, waiting for a pressed sample
// ST_PRESS_DB   | pressed level seen, counting stable cycles before accept
// ST_HELD       | press accepted, timing toward the long-press threshold
// ST_LONG_HELD  | long press reached, waiting for release (and repeating)
// ST_RELEASE_DB | released level seen, counting stable cycles before accept
module key_event
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W    = cnt_width(DB_CYCLES);
    localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    logic key_s;
    logic key_n;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                long_f_q, long_f_d;
    logic                level_d;
    logic                press_d;
    logic                release_d;
    logic                long_d;
`ifdef KEY_EVENT_REPEAT_EN
    logic                repeat_d;
`endif

    key_sync u_key_sync (
        .clk (clk),
        .rst (rst),
        .d   (key),
        .q   (key_s)
    );

    assign key_n = ~key_s;

    // Next-state, counter and pulse decode; pulses are registered below so
    // every output is a clean flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        long_f_d   = long_f_q;
        level_d    = key_level;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        repeat_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                level_d = 1'b0;
                if (key_n) begin
                    state_d = ST_PRESS_DB;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!key_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d    = ST_HELD;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_n) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d    = ST_LONG_HELD;
                    long_d     = 1'b1;
                    long_f_d   = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_LONG_HELD: begin
                if (!key_n) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (hold_cnt_q == REP_LAST) begin
                    repeat_d   = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end
            ST_RELEASE_DB: begin
                // hold_cnt stays frozen so a release bounce only pauses timing.
                if (key_n) begin
                    state_d = long_f_q ? ST_LONG_HELD : ST_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    long_f_d  = 1'b0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset drops any press in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hold_cnt_q    <= '0;
            long_f_q      <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_f_q      <= long_f_d;
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    // Auto-repeat pulse register, present only with the repeat feature.
    always_ff @(posedge clk) begin
        if (!rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
